// File: rtl/nand_gate_exerciser.sv
// rtl/nand_gate_exerciser.sv - exhaustive pattern driver and response checker for multi-block NAND parts
module nand_gate_exerciser #(
  parameter int BLOCKS   = 2,
  parameter int WIDTH_IN = 4,
  parameter int SETTLE   = 8
) (
  input  logic                         Clk,
  input  logic                         Clear,
  input  logic                         Start,
  output logic [BLOCKS*WIDTH_IN-1:0]   A_2D,
  input  logic [BLOCKS-1:0]            Y,
  output logic                         Busy,
  output logic                         Done,
  output logic                         Pass,
  output logic [BLOCKS-1:0]            Fail_Block,
  output logic [WIDTH_IN-1:0]          Fail_Pattern
);

  // Settle counter only has to hold SETTLE-1, but never shrinks below one bit.
  localparam int CW = (SETTLE <= 2) ? 1 : $clog2(SETTLE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t                      state_q, state_d;
  logic [WIDTH_IN-1:0]         pattern_q, pattern_d;
  logic [CW-1:0]               count_q, count_d;
  logic                        first_fail_q, first_fail_d;
  logic [BLOCKS*WIDTH_IN-1:0]  a_2d_q, a_2d_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        pass_q, pass_d;
  logic [BLOCKS-1:0]           fail_block_q, fail_block_d;
  logic [WIDTH_IN-1:0]         fail_pattern_q, fail_pattern_d;
  logic [BLOCKS-1:0]           mism;

  // Next-state and next-output logic; outputs are derived from the next state so they leave the flops aligned with it.
  always_comb begin
    state_d        = state_q;
    pattern_d      = pattern_q;
    count_d        = count_q;
    first_fail_d   = first_fail_q;
    fail_block_d   = fail_block_q;
    fail_pattern_d = fail_pattern_q;
    // Every block sees the same pattern, so one expected NAND value serves all of them.
    mism           = Y ^ {BLOCKS{~&pattern_q}};

    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_d        = S_APPLY;
          pattern_d      = '0;
          fail_block_d   = '0;
          fail_pattern_d = '0;
          first_fail_d   = 1'b0;
        end
      end
      S_APPLY: begin
        count_d = CW'(SETTLE - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (count_q == '0) begin
          state_d = S_CHECK;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      S_CHECK: begin
        fail_block_d = fail_block_q | mism;
        if (|mism && !first_fail_q) begin
          fail_pattern_d = pattern_q;
          first_fail_d   = 1'b1;
        end
        if (&pattern_q) begin
          state_d = S_DONE;
        end else begin
          pattern_d = pattern_q + WIDTH_IN'(1);
          state_d   = S_APPLY;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_APPLY) || (state_d == S_WAIT) || (state_d == S_CHECK);
    done_d = (state_d == S_DONE);
    pass_d = done_d && (fail_block_d == '0);
    a_2d_d = busy_d ? {BLOCKS{pattern_d}} : '0;
  end

  // State and registered outputs; Clear overrides everything, including a sweep in progress.
  always_ff @(posedge Clk) begin
    if (Clear) begin
      state_q        <= S_IDLE;
      pattern_q      <= '0;
      count_q        <= '0;
      first_fail_q   <= 1'b0;
      a_2d_q         <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      fail_block_q   <= '0;
      fail_pattern_q <= '0;
    end else begin
      state_q        <= state_d;
      pattern_q      <= pattern_d;
      count_q        <= count_d;
      first_fail_q   <= first_fail_d;
      a_2d_q         <= a_2d_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      pass_q         <= pass_d;
      fail_block_q   <= fail_block_d;
      fail_pattern_q <= fail_pattern_d;
    end
  end

  assign A_2D         = a_2d_q;
  assign Busy         = busy_q;
  assign Done         = done_q;
  assign Pass         = pass_q;
  assign Fail_Block   = fail_block_q;
  assign Fail_Pattern = fail_pattern_q;

endmodule
